calc_entry: RTL and testbench

Consumer of decoded keypad events. Takes the one-cycle key strobes and flags from the keypad scanner (is_num / is_op / is_eq with num_val / op_val) and assembles two BCD operands and an operator. It then hands them to the arithmetic unit with a req/ack handshake and drives the BCD value currently being typed to the display path. It sits between the keypad scanner and the ALU in the calculator top level.

---
 rtl/calc_entry_if.sv | 32 +++
 rtl/calc_entry.sv | 111 +++++++++++
 tb/tb_calc_entry.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_entry_if.sv
// Keypad-event / ALU-request bundle for calc_entry.
// The scanner side drives keys and ack (master); calc_entry drives operands and status (slave).
interface calc_entry_if #(
  parameter int DIGITS = 4
);
  localparam int W = 4 * DIGITS;

  logic         key_stb;
  logic         is_num;
  logic         is_op;
  logic         is_eq;
  logic [3:0]   num_val;
  logic [1:0]   op_val;
  logic         calc_ack;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [1:0]   op_out;
  logic         calc_req;
  logic [W-1:0] disp_bcd;
  logic [1:0]   phase;
  logic         ovf;

  modport master (
    output key_stb, is_num, is_op, is_eq, num_val, op_val, calc_ack,
    input  operand_a, operand_b, op_out, calc_req, disp_bcd, phase, ovf
  );

  modport slave (
    input  key_stb, is_num, is_op, is_eq, num_val, op_val, calc_ack,
    output operand_a, operand_b, op_out, calc_req, disp_bcd, phase, ovf
  );
endinterface

// File: rtl/calc_entry.sv
// Assembles two BCD operands and an operator from keypad events, then
// requests the ALU with a level req held until ack.
module calc_entry #(
  parameter int DIGITS = 4
) (
  input logic        clk,
  input logic        rst_n,
  calc_entry_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    REQ     = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a, b, disp;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [1:0]    op;
  logic          req, ovf;

  logic [W-1:0]  a_next, b_next;
  logic          digit_ok;

  // Shift the new digit into the low nibble; the top digit falls off the truncation.
  always_comb begin
    a_next   = W'({a, bus.num_val});
    b_next   = W'({b, bus.num_val});
    digit_ok = bus.is_num && (bus.num_val <= 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENTER_A;
      a     <= '0;
      b     <= '0;
      disp  <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      op    <= '0;
      req   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ENTER_A: begin
          if (bus.key_stb && !bus.is_eq) begin
            if (bus.is_op) begin
              op    <= bus.op_val;
              b     <= '0;
              cnt_b <= '0;
              disp  <= '0;
              state <= ENTER_B;
            end else if (digit_ok && !(bus.num_val == 4'd0 && cnt_a == '0)) begin
              if (cnt_a != FULL) begin
                a     <= a_next;
                disp  <= a_next;
                cnt_a <= cnt_a + CW'(1);
              end else begin
                ovf <= 1'b1;
              end
            end
          end
        end
        ENTER_B: begin
          if (bus.key_stb) begin
            if (bus.is_eq) begin
              req   <= 1'b1;
              state <= REQ;
            end else if (bus.is_op) begin
              if (cnt_b == '0) op <= bus.op_val;
            end else if (digit_ok && !(bus.num_val == 4'd0 && cnt_b == '0)) begin
              if (cnt_b != FULL) begin
                b     <= b_next;
                disp  <= b_next;
                cnt_b <= cnt_b + CW'(1);
              end else begin
                ovf <= 1'b1;
              end
            end
          end
        end
        REQ: begin
          if (bus.calc_ack) begin
            req   <= 1'b0;
            a     <= '0;
            b     <= '0;
            disp  <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
            op    <= '0;
            ovf   <= 1'b0;
            state <= ENTER_A;
          end
        end
        default: state <= ENTER_A;
      endcase
    end
  end

  assign bus.operand_a = a;
  assign bus.operand_b = b;
  assign bus.op_out    = op;
  assign bus.calc_req  = req;
  assign bus.disp_bcd  = disp;
  assign bus.phase     = state;
  assign bus.ovf       = ovf;
endmodule

// File: tb/tb_calc_entry.sv
// Randomized and directed checks of calc_entry against a decimal-value reference model.
module tb_calc_entry;
  localparam int DIGITS = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  calc_entry_if #(.DIGITS(DIGITS)) bus ();

  calc_entry #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: operands kept as plain decimal integers with digit counts.
  int m_a, m_b, m_na, m_nb, m_op, m_ph, m_req, m_ovf;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
    m_op = 0; m_ph = 0; m_req = 0; m_ovf = 0;
  endtask

  task automatic model_digit(inout int val, inout int n, input int d);
    if (val == 0 && d == 0) return;
    if (n < DIGITS) begin
      val = val * 10 + d;
      n   = n + 1;
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic model_step(input logic stb, input logic num, input logic op, input logic eq,
                            input int nv, input int ov, input logic ack);
    if (m_ph == 2) begin
      if (ack) model_reset();
    end else if (stb) begin
      if (eq) begin
        if (m_ph == 1) begin
          m_req = 1;
          m_ph  = 2;
        end
      end else if (op) begin
        if (m_ph == 0) begin
          m_op = ov; m_b = 0; m_nb = 0; m_ph = 1;
        end else if (m_nb == 0) begin
          m_op = ov;
        end
      end else if (num && nv <= 9) begin
        if (m_ph == 0) model_digit(m_a, m_na, nv);
        else           model_digit(m_b, m_nb, nv);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a"},    32'(bus.operand_a), to_bcd(m_a));
    check({tag, ".b"},    32'(bus.operand_b), to_bcd(m_b));
    check({tag, ".op"},   32'(bus.op_out),    32'(m_op));
    check({tag, ".req"},  32'(bus.calc_req),  32'(m_req));
    check({tag, ".disp"}, 32'(bus.disp_bcd),  to_bcd(m_ph == 0 ? m_a : m_b));
    check({tag, ".ph"},   32'(bus.phase),     32'(m_ph));
    check({tag, ".ovf"},  32'(bus.ovf),       32'(m_ovf));
  endtask

  // Called just after a rising edge: drive, advance one edge, compare.
  task automatic step(input logic stb, input logic num, input logic op, input logic eq,
                      input logic [3:0] nv, input logic [1:0] ov, input logic ack,
                      input string tag);
    bus.key_stb  = stb;
    bus.is_num   = num;
    bus.is_op    = op;
    bus.is_eq    = eq;
    bus.num_val  = nv;
    bus.op_val   = ov;
    bus.calc_ack = ack;
    model_step(stb, num, op, eq, int'(nv), int'(ov), ack);
    @(posedge clk);
    #1;
    check_all(tag);
    bus.key_stb  = 1'b0;
    bus.calc_ack = 1'b0;
  endtask

  task automatic dig(input int d);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'(d), 2'd0, 1'b0, "dig");
  endtask
  task automatic opk(input int o);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 2'(o), 1'b0, "op");
  endtask
  task automatic eqk();
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0, 1'b0, "eq");
  endtask
  task automatic idle(input logic ack);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, ack, "idle");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n        = 1'b0;
    bus.key_stb  = 1'b0;
    bus.is_num   = 1'b0;
    bus.is_op    = 1'b0;
    bus.is_eq    = 1'b0;
    bus.num_val  = '0;
    bus.op_val   = '0;
    bus.calc_ack = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic transaction 123 op1 45 =, ack on third REQ cycle.
    dig(1); dig(2); dig(3); opk(1); dig(4); dig(5); eqk();
    check("tp1_a",  32'(bus.operand_a), 32'h0123);
    check("tp1_b",  32'(bus.operand_b), 32'h0045);
    check("tp1_op", 32'(bus.op_out),    32'd1);
    check("tp1_req", 32'(bus.calc_req), 32'd1);
    check("tp1_ph", 32'(bus.phase),     32'd2);
    idle(1'b0); idle(1'b0); idle(1'b1);
    check("tp1_exit_ph", 32'(bus.phase), 32'd0);

    // Leading zeros and overflow.
    dig(0); dig(0); dig(7);
    check("lz_a", 32'(bus.operand_a), 32'h0007);
    for (int i = 0; i < 5; i++) dig(9);
    check("ovf_a", 32'(bus.operand_a), 32'h7999);
    check("ovf_f", 32'(bus.ovf), 32'd1);

    // Ignored events in ENTER_A, then all-flags event acting as eq.
    eqk();
    dig(12);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 2'd2, 1'b0, "multiA");
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 2'd2, 1'b0, "nostb");
    idle(1'b1);
    opk(0); opk(3);
    check("oprep", 32'(bus.op_out), 32'd3);
    dig(3); opk(2);
    check("opkeep", 32'(bus.op_out), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 2'd2, 1'b0, "multiB");
    check("multiB_req", 32'(bus.calc_req), 32'd1);
    dig(5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 2'd0, 1'b1, "ack_key");
    idle(1'b1); idle(1'b1);
    check("ack_key_a", 32'(bus.operand_a), 32'h0000);

    // Asynchronous reset mid-REQ, between edges.
    dig(8); opk(1); eqk(); idle(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int   kind;
      logic stb, num, op, eq;
      kind = int'($urandom_range(0, 9));
      stb  = ($urandom_range(0, 4) != 0);
      num  = (kind <= 4);
      op   = (kind == 5 || kind == 6);
      eq   = (kind == 7);
      if (kind == 8) begin
        num = 1'($urandom_range(0, 1));
        op  = 1'($urandom_range(0, 1));
        eq  = 1'($urandom_range(0, 1));
      end
      step(stb, num, op, eq, 4'($urandom_range(0, 11)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
